// File: rtl/spi_peripheral_tx_if.sv
// Upstream byte handshake between the result/controller logic and the SPI transmitter.
interface spi_peripheral_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              byte_sent;
  logic              underrun;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, byte_sent, underrun
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, byte_sent, underrun
  );
endinterface

// File: rtl/spi_peripheral_tx.sv
// SPI mode-0 peripheral transmitter, fully in the clk domain with oversampled SCLK/CS.
// Optional saturating underrun counter enabled by defining SPI_TX_UNDERRUN_CNT_EN.
module spi_peripheral_tx #(
  parameter int               DATA_W      = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE  = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  input  logic spi_cs_n_i,
  output logic cipo_o,
  output logic cipo_oe_o,
`ifdef SPI_TX_UNDERRUN_CNT_EN
  output logic [7:0] underrun_count_o,
`endif
  spi_peripheral_tx_if.slave tx_if
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              pending_q, pending_d;
  logic              cipo_q, cipo_d;
  logic              byte_sent_q, byte_sent_d;
  logic              underrun_q, underrun_d;
  logic              load;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic                   sclk_s, cs_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  // CS idles high so the chain resets to 1 and no false cs_fall appears at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      pending_q   <= 1'b0;
      cipo_q      <= 1'b0;
      byte_sent_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      pending_q   <= pending_d;
      cipo_q      <= cipo_d;
      byte_sent_q <= byte_sent_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    pending_d   = pending_q;
    cipo_d      = cipo_q;
    byte_sent_d = 1'b0;
    underrun_d  = 1'b0;
    load        = 1'b0;

    // cs_rise outranks any SCLK edge seen in the same cycle.
    if (cs_rise) begin
      state_d   = IDLE;
      cipo_d    = 1'b0;
      bit_cnt_d = '0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            load    = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d   = '0;
              byte_sent_d = 1'b1;
              pending_d   = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (sclk_fall) begin
            if (pending_q) begin
              load      = 1'b1;
              pending_d = 1'b0;
            end else begin
              shift_d = {shift_q[DATA_W-2:0], 1'b0};
              cipo_d  = shift_q[DATA_W-2];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (load) begin
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        shift_d    = IDLE_BYTE;
        underrun_d = 1'b1;
      end
      cipo_d = shift_d[DATA_W-1];
    end

    // An underrun load leaves the register empty, so a same-cycle write is still taken.
    if (tx_if.tx_valid && !hold_full_q) begin
      hold_full_d = 1'b1;
      hold_d      = tx_if.tx_data;
    end
  end

  assign cipo_o          = cipo_q;
  assign cipo_oe_o       = (state_q == SHIFT);
  assign tx_if.tx_ready  = ~hold_full_q;
  assign tx_if.byte_sent = byte_sent_q;
  assign tx_if.underrun  = underrun_q;

`ifdef SPI_TX_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else if (underrun_q && (ucnt_q != 8'hFF)) begin
      ucnt_q <= ucnt_q + 8'd1;
    end
  end

  assign underrun_count_o = ucnt_q;
`endif

endmodule

// File: tb/tb_spi_peripheral_tx.sv
// Self-checking bench: expected CIPO bits are queued per written byte and popped at each SCLK rise.
module tb_spi_peripheral_tx;
  localparam int         DATA_W      = 8;
  localparam int         SYNC_STAGES = 2;
  localparam int         HALF        = 8;
  localparam logic [7:0] IDLE_BYTE   = 8'h00;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic sclk  = 1'b0;
  logic cs_n  = 1'b1;
  logic cipo;
  logic cipo_oe;
`ifdef SPI_TX_UNDERRUN_CNT_EN
  logic [7:0] underrun_count;
`endif

  spi_peripheral_tx_if #(.DATA_W(DATA_W)) tx_if ();

  spi_peripheral_tx #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_BYTE   (IDLE_BYTE)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sclk_i           (sclk),
    .spi_cs_n_i       (cs_n),
    .cipo_o           (cipo),
    .cipo_oe_o        (cipo_oe),
`ifdef SPI_TX_UNDERRUN_CNT_EN
    .underrun_count_o (underrun_count),
`endif
    .tx_if            (tx_if.slave)
  );

  always #5 clk = ~clk;

  int   checks    = 0;
  int   errors    = 0;
  int   sent_cnt  = 0;
  int   under_cnt = 0;
  logic exp_bits[$];

  // Pulse counters sampled away from the active edge; a stretched pulse counts twice.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_if.byte_sent) sent_cnt++;
      if (tx_if.underrun) under_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not finish (errors so far %0d)", errors);
    $fatal(1, "[TB] watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  task automatic write_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!tx_if.tx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_if.tx_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL write_timeout byte %h tx_ready=%b required 1", b, tx_if.tx_ready);
    end else begin
      tx_if.tx_data  = b;
      tx_if.tx_valid = 1'b1;
      push_byte(b);
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
    end
  endtask

  task automatic frame_bits(input int n);
    logic exp;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (exp_bits.size() == 0) begin
        errors++;
        $display("[TB] FAIL cipo_bit %0d no expected bit queued, cipo=%b", i, cipo);
      end else begin
        exp = exp_bits.pop_front();
        if (cipo !== exp) begin
          errors++;
          $display("[TB] FAIL cipo_bit %0d got %b required %b", i, cipo, exp);
        end
      end
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i < n - 1) begin
        sclk = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  // SCLK and CS change together, so the frame ends without a final fall-triggered load.
  task automatic end_frame();
    sclk = 1'b0;
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cipo !== 1'b0) begin errors++; $display("[TB] FAIL reset_cipo got %b required 0", cipo); end
    checks++; if (cipo_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe got %b required 0", cipo_oe); end
    checks++; if (tx_if.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b required 1", tx_if.tx_ready); end
    checks++; if (tx_if.byte_sent !== 1'b0) begin errors++; $display("[TB] FAIL reset_sent got %b required 0", tx_if.byte_sent); end
    checks++; if (tx_if.underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun got %b required 0", tx_if.underrun); end
`ifdef SPI_TX_UNDERRUN_CNT_EN
    checks++; if (underrun_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_ucount got %0d required 0", underrun_count); end
`endif
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int s0 = sent_cnt;
    int u0 = under_cnt;
    write_byte(8'hA5);
    checks++; if (tx_if.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_full got tx_ready=%b required 0", tx_if.tx_ready); end
    frame_bits(8);
    checks++; if (tx_if.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_loaded got tx_ready=%b required 1", tx_if.tx_ready); end
    end_frame();
    checks++; if (sent_cnt - s0 != 1) begin errors++; $display("[TB] FAIL single_sent got %0d required 1", sent_cnt - s0); end
    checks++; if (under_cnt - u0 != 0) begin errors++; $display("[TB] FAIL single_underrun got %0d required 0", under_cnt - u0); end
  endtask

  task automatic test_streaming();
    int s0 = sent_cnt;
    int u0 = under_cnt;
    write_byte(8'h3C);
    fork
      frame_bits(16);
      write_byte(8'hC3);
    join
    end_frame();
    checks++; if (sent_cnt - s0 != 2) begin errors++; $display("[TB] FAIL stream_sent got %0d required 2", sent_cnt - s0); end
    checks++; if (under_cnt - u0 != 0) begin errors++; $display("[TB] FAIL stream_underrun got %0d required 0", under_cnt - u0); end
    checks++; if (exp_bits.size() != 0) begin errors++; $display("[TB] FAIL stream_leftover got %0d bits required 0", exp_bits.size()); end
  endtask

  task automatic test_underrun();
    int s0 = sent_cnt;
    int u0 = under_cnt;
    push_byte(IDLE_BYTE);
    frame_bits(8);
    end_frame();
    checks++; if (sent_cnt - s0 != 1) begin errors++; $display("[TB] FAIL underrun_sent got %0d required 1", sent_cnt - s0); end
    checks++; if (under_cnt - u0 != 1) begin errors++; $display("[TB] FAIL underrun_pulse got %0d required 1", under_cnt - u0); end
`ifdef SPI_TX_UNDERRUN_CNT_EN
    checks++; if (underrun_count !== 8'd1) begin errors++; $display("[TB] FAIL underrun_count got %0d required 1", underrun_count); end
`endif
  endtask

  task automatic test_abort();
    int s0 = sent_cnt;
    int u0 = under_cnt;
    write_byte(8'hF0);
    fork
      frame_bits(4);
      write_byte(8'h0F);
    join
    sclk = 1'b0;
    cs_n = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    checks++; if (cipo_oe !== 1'b0) begin errors++; $display("[TB] FAIL abort_oe got %b required 0", cipo_oe); end
    checks++; if (cipo !== 1'b0) begin errors++; $display("[TB] FAIL abort_cipo got %b required 0", cipo); end
    repeat (HALF) @(negedge clk);
    checks++; if (sent_cnt - s0 != 0) begin errors++; $display("[TB] FAIL abort_sent got %0d required 0", sent_cnt - s0); end
    repeat (4) void'(exp_bits.pop_front());
    frame_bits(8);
    end_frame();
    checks++; if (sent_cnt - s0 != 1) begin errors++; $display("[TB] FAIL abort_next_sent got %0d required 1", sent_cnt - s0); end
    checks++; if (under_cnt - u0 != 0) begin errors++; $display("[TB] FAIL abort_underrun got %0d required 0", under_cnt - u0); end
  endtask

  task automatic test_reset_mid_byte();
    int s0;
    int u0;
    write_byte(8'h81);
    fork
      frame_bits(3);
      write_byte(8'h7E);
    join
    checks++; if (cipo_oe !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre_oe got %b required 1", cipo_oe); end
    checks++; if (tx_if.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pre_ready got %b required 0", tx_if.tx_ready); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    #1;
    checks++; if (cipo !== 1'b0) begin errors++; $display("[TB] FAIL midrst_cipo got %b required 0", cipo); end
    checks++; if (cipo_oe !== 1'b0) begin errors++; $display("[TB] FAIL midrst_oe got %b required 0", cipo_oe); end
    checks++; if (tx_if.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_ready got %b required 1", tx_if.tx_ready); end
    checks++; if (tx_if.byte_sent !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sent got %b required 0", tx_if.byte_sent); end
    checks++; if (tx_if.underrun !== 1'b0) begin errors++; $display("[TB] FAIL midrst_underrun got %b required 0", tx_if.underrun); end
    exp_bits.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    s0 = sent_cnt;
    u0 = under_cnt;
    push_byte(IDLE_BYTE);
    frame_bits(8);
    end_frame();
    checks++; if (sent_cnt - s0 != 1) begin errors++; $display("[TB] FAIL midrst_after_sent got %0d required 1", sent_cnt - s0); end
    checks++; if (under_cnt - u0 != 1) begin errors++; $display("[TB] FAIL midrst_after_underrun got %0d required 1", under_cnt - u0); end
`ifdef SPI_TX_UNDERRUN_CNT_EN
    checks++; if (underrun_count !== 8'd1) begin errors++; $display("[TB] FAIL midrst_ucount got %0d required 1", underrun_count); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_underrun();
    test_abort();
    test_reset_mid_byte();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
